// File: rtl/lector_salidas_rr.sv
// Round-robin consumer for output FIFOs F4..F7: pops, registers the returning word, counts words per channel.
// Optional DEST_CHECK_EN macro adds sticky destination-mismatch flags on err_dest.
module lector_salidas_rr #(
    parameter int TAMANO_DATOS = 12,
    parameter int CNT_W        = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    init,
    input  logic [3:0]              pop_en,
    input  logic [3:0]              empty,
    input  logic [TAMANO_DATOS-1:0] data_out4,
    input  logic [TAMANO_DATOS-1:0] data_out5,
    input  logic [TAMANO_DATOS-1:0] data_out6,
    input  logic [TAMANO_DATOS-1:0] data_out7,
    input  logic                    req,
    input  logic [2:0]              idx,
    output logic [3:0]              pop,
    output logic [TAMANO_DATOS-1:0] data_rx,
    output logic                    data_valid,
    output logic [1:0]              canal_rx,
    output logic [CNT_W-1:0]        cnt_out,
    output logic                    cnt_valid,
    output logic [3:0]              err_dest
);

    localparam int NCH = 4;

    logic [NCH-1:0]          pop_reg;
    logic [NCH-1:0]          pop_next;
    logic [1:0]              rr_ptr_reg;
    logic [1:0]              rr_ptr_next;
    logic                    pend_valid_reg;
    logic [1:0]              pend_ch_reg;
    logic [TAMANO_DATOS-1:0] data_rx_reg;
    logic                    data_valid_reg;
    logic [1:0]              canal_rx_reg;
    logic [CNT_W-1:0]        cnt_out_reg;
    logic                    cnt_valid_reg;
    logic [NCH*CNT_W-1:0]    cnt_flat;
    logic [CNT_W-1:0]        cnt_sel;
    logic [NCH-1:0]          elig;
    logic [TAMANO_DATOS-1:0] data_in [NCH];
    logic [TAMANO_DATOS-1:0] data_sel;
    logic [1:0]              pop_ch;
    logic [1:0]              cand;
    logic                    found;

    genvar gi;

    assign data_in[0] = data_out4;
    assign data_in[1] = data_out5;
    assign data_in[2] = data_out6;
    assign data_in[3] = data_out7;

    // A channel popped this cycle still shows its stale empty flag, so it sits out one cycle.
    assign elig = pop_en & ~empty & ~pop_reg;

    always_comb begin
        pop_next    = '0;
        rr_ptr_next = rr_ptr_reg;
        found       = 1'b0;
        cand        = '0;
        for (int k = 0; k < NCH; k++) begin
            cand = rr_ptr_reg + 2'(k);
            if (!found && elig[cand]) begin
                found          = 1'b1;
                pop_next[cand] = 1'b1;
                rr_ptr_next    = cand + 2'd1;
            end
        end
    end

    assign pop_ch   = {pop_reg[3] | pop_reg[2], pop_reg[3] | pop_reg[1]};
    assign data_sel = data_in[pend_ch_reg];
    assign cnt_sel  = cnt_flat[idx[1:0]*CNT_W +: CNT_W];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pop_reg        <= '0;
            rr_ptr_reg     <= '0;
            pend_valid_reg <= 1'b0;
            pend_ch_reg    <= '0;
            data_rx_reg    <= '0;
            data_valid_reg <= 1'b0;
            canal_rx_reg   <= '0;
            cnt_out_reg    <= '0;
            cnt_valid_reg  <= 1'b0;
        end else if (init) begin
            pop_reg        <= '0;
            rr_ptr_reg     <= '0;
            pend_valid_reg <= 1'b0;
            pend_ch_reg    <= '0;
            data_rx_reg    <= '0;
            data_valid_reg <= 1'b0;
            canal_rx_reg   <= '0;
            cnt_out_reg    <= '0;
            cnt_valid_reg  <= 1'b0;
        end else begin
            pop_reg        <= pop_next;
            rr_ptr_reg     <= rr_ptr_next;
            // The FIFO drives the popped word during the following cycle.
            pend_valid_reg <= |pop_reg;
            pend_ch_reg    <= pop_ch;
            data_valid_reg <= pend_valid_reg;
            if (pend_valid_reg) begin
                data_rx_reg  <= data_sel;
                canal_rx_reg <= pend_ch_reg;
            end
            cnt_valid_reg <= req;
            if (req) begin
                cnt_out_reg <= idx[2] ? cnt_sel : '0;
            end
        end
    end

    for (gi = 0; gi < NCH; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_reg;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt_reg <= '0;
            end else if (init) begin
                cnt_reg <= '0;
            end else if (data_valid_reg && canal_rx_reg == 2'(gi)) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end

        assign cnt_flat[gi*CNT_W +: CNT_W] = cnt_reg;
    end

`ifdef DEST_CHECK_EN
    // Checked as the word is captured, so the flag rises together with data_valid.
    for (gi = 0; gi < NCH; gi++) begin : g_err
        logic err_flag_reg;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                err_flag_reg <= 1'b0;
            end else if (init) begin
                err_flag_reg <= 1'b0;
            end else if (pend_valid_reg && pend_ch_reg == 2'(gi) &&
                         data_sel[9:8] != 2'(gi)) begin
                err_flag_reg <= 1'b1;
            end
        end

        assign err_dest[gi] = err_flag_reg;
    end
`else
    assign err_dest = '0;
`endif

    assign pop        = pop_reg;
    assign data_rx    = data_rx_reg;
    assign data_valid = data_valid_reg;
    assign canal_rx   = canal_rx_reg;
    assign cnt_out    = cnt_out_reg;
    assign cnt_valid  = cnt_valid_reg;

endmodule
